mul_sequencer: RTL and testbench

- Multi-cycle controller that computes the unsigned 8086 MUL product (8x8->16, 16x16->32) by sequencing the shared ALU through one ADD per multiplier bit.
- Owns the ALU's a/b/op/is_8_bit inputs while busy. Shift-add iteration: accumulator high half plus multiplier low half, shifted right one bit per cycle.
- Sits beside the microcode sequencer. The microcode pulses start, stalls on busy, then writes result to AX (8-bit) or DX:AX (16-bit) and updates CF/OF.

---
 rtl/mul_sequencer_pkg.sv | 20 ++
 rtl/mul_sequencer.sv | 129 ++++++++++++
 tb/tb_mul_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared micro-architecture constants used by the MUL sequencer and the
// core-level ALU mux: ALU operation encodings, the ALU op field width and
// the flag bit positions in the 8086 FLAGS word.
package mul_sequencer_pkg;

  localparam int MC_ALUOp_t_BITS = 5;

  localparam logic [MC_ALUOp_t_BITS-1:0] ALUOp_SELA = 5'd0;
  localparam logic [MC_ALUOp_t_BITS-1:0] ALUOp_ADD  = 5'd1;
  localparam logic [MC_ALUOp_t_BITS-1:0] ALUOp_ADC  = 5'd2;
  localparam logic [MC_ALUOp_t_BITS-1:0] ALUOp_SUB  = 5'd3;
  localparam logic [MC_ALUOp_t_BITS-1:0] ALUOp_AND  = 5'd4;
  localparam logic [MC_ALUOp_t_BITS-1:0] ALUOp_OR   = 5'd5;
  localparam logic [MC_ALUOp_t_BITS-1:0] ALUOp_XOR  = 5'd6;

  // FLAGS bit positions
  localparam int CF_IDX = 0;
  localparam int OF_IDX = 11;

endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle unsigned 8086 MUL (8x8->16, 16x16->32).
// Drives the shared ALU with one ADD per multiplier bit (shift-add), taking
// a fixed 8 or 16 iterations regardless of operand values.
//
// Ports:
//   clk, reset         core clock, synchronous active-high reset
//   start              begin multiply (honoured in IDLE/DONE only)
//   is_8_bit           operand size, sampled with start
//   multiplicand       operand A (upper byte ignored in 8-bit mode)
//   multiplier         operand B (upper byte ignored in 8-bit mode)
//   busy               high while iterating
//   complete           one-cycle pulse when the product is ready
//   result             registered product; [31:16]=0 in 8-bit mode
//   cf_of              registered CF/OF value: upper half of product non-zero
//   alu_a/alu_b/alu_op/alu_is_8_bit   ALU inputs (owned only while busy)
//   alu_out, alu_flags_out            ALU results (only CF is used)
module mul_sequencer
  import mul_sequencer_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       is_8_bit,
  input  logic [15:0]                multiplicand,
  input  logic [15:0]                multiplier,
  output logic                       busy,
  output logic                       complete,
  output logic [31:0]                result,
  output logic                       cf_of,
  output logic [15:0]                alu_a,
  output logic [15:0]                alu_b,
  output logic [MC_ALUOp_t_BITS-1:0] alu_op,
  output logic                       alu_is_8_bit,
  input  logic [15:0]                alu_out,
  input  logic [15:0]                alu_flags_out
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] hi, lo, mcand;
  logic [15:0] hi_nxt, lo_nxt;
  logic [3:0]  count;
  logic        size;
  logic        carry;
  logic        accept;
  logic        unused_flags;

  // Only the carry flag matters to the shift-add loop.
  assign carry        = alu_flags_out[CF_IDX];
  assign unused_flags = ^(alu_flags_out & ~(16'h1 << CF_IDX));

  assign accept = start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus status and ALU drive. Outside ITER the ALU sees a
  // harmless SELA of zero so no flags are disturbed.
  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    complete     = 1'b0;
    alu_op       = ALUOp_SELA;
    alu_a        = '0;
    alu_b        = '0;
    alu_is_8_bit = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_ITER;
      S_ITER: begin
        busy         = 1'b1;
        alu_op       = ALUOp_ADD;
        alu_a        = hi;
        alu_b        = lo[0] ? mcand : 16'h0;
        alu_is_8_bit = size;
        if (count == 4'd0) state_nxt = S_DONE;
      end
      S_DONE: begin
        complete  = 1'b1;
        state_nxt = start ? S_ITER : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One shift-add step: the ALU carry becomes the new top bit of the
  // accumulator and the accumulator LSB drops into the vacated top of lo.
  always_comb begin
    if (size) begin
      hi_nxt = {8'h0, carry, alu_out[7:1]};
      lo_nxt = {8'h0, alu_out[0], lo[7:1]};
    end else begin
      hi_nxt = {carry, alu_out[15:1]};
      lo_nxt = {alu_out[0], lo[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      count  <= '0;
      size   <= 1'b0;
      result <= '0;
      cf_of  <= 1'b0;
    end else if (accept) begin
      mcand <= is_8_bit ? {8'h0, multiplicand[7:0]} : multiplicand;
      lo    <= is_8_bit ? {8'h0, multiplier[7:0]}   : multiplier;
      hi    <= '0;
      size  <= is_8_bit;
      count <= is_8_bit ? 4'd7 : 4'd15;
    end else if (state == S_ITER) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
      if (count != 4'd0) begin
        count <= count - 4'd1;
      end else begin
        // Last step: capture from the post-step values so result is
        // already valid in the DONE cycle.
        result <= size ? {16'h0, hi_nxt[7:0], lo_nxt[7:0]} : {hi_nxt, lo_nxt};
        cf_of  <= size ? |hi_nxt[7:0] : |hi_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: a behavioural ALU answers the DUT's ALU requests,
// directed operations push expected products into a queue, and a monitor
// pops and compares on every complete pulse (value, CF/OF, latency) while
// also checking ALU drive every cycle.
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       start = 1'b0;
  logic                       is_8_bit = 1'b0;
  logic [15:0]                multiplicand = '0;
  logic [15:0]                multiplier = '0;
  logic                       busy, complete, cf_of, alu_is_8_bit;
  logic [31:0]                result;
  logic [15:0]                alu_a, alu_b, alu_out, alu_flags_out;
  logic [MC_ALUOp_t_BITS-1:0] alu_op;

  mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_8_bit(is_8_bit),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .complete(complete), .result(result), .cf_of(cf_of),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_8_bit(alu_is_8_bit),
    .alu_out(alu_out), .alu_flags_out(alu_flags_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; non-CF flag bits carry a fixed pattern.
  logic [16:0] sum;
  always_comb begin
    alu_out       = alu_a;
    alu_flags_out = 16'h8AA0;
    sum           = '0;
    if (alu_op == ALUOp_ADD) begin
      if (alu_is_8_bit) begin
        sum = {9'h0, alu_a[7:0]} + {9'h0, alu_b[7:0]};
        alu_out = {8'h0, sum[7:0]};
        alu_flags_out[CF_IDX] = sum[8];
      end else begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = sum[15:0];
        alu_flags_out[CF_IDX] = sum[16];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        cf;
    logic        is8;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: ALU ownership rules every cycle, scoreboard on complete.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        chk("alu_op_iter", 32'(alu_op), 32'(ALUOp_ADD));
        if (exp_q.size() > 0) begin
          chk("alu_size", 32'(alu_is_8_bit), 32'(exp_q[0].is8));
          if (exp_q[0].is8) chk("alu_a_hi_zero", 32'(alu_a[15:8]), 32'h0);
        end
      end else begin
        chk("alu_op_idle", 32'(alu_op), 32'(ALUOp_SELA));
        chk("alu_a_idle", 32'(alu_a), 32'h0);
        chk("alu_b_idle", 32'(alu_b), 32'h0);
        chk("alu_size_idle", 32'(alu_is_8_bit), 32'h0);
      end
      if (complete) begin
        chk("busy_in_done", 32'(busy), 32'h0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_complete: got complete=1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("cf_of", 32'(cf_of), 32'(e.cf));
          chk("latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // Assumes the caller sits at a negedge; holds start for one cycle.
  task automatic issue_now(input bit is8, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] er, input bit ecf, input bit accepted);
    start = 1'b1; is_8_bit = is8; multiplicand = a; multiplier = b;
    if (accepted) exp_q.push_back('{er, ecf, is8, cyc + (is8 ? 9 : 17)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input bit is8, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] er, input bit ecf);
    @(negedge clk);
    issue_now(is8, a, b, er, ecf, 1'b1);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int due;
    int guard;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_complete", 32'(complete), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_cf_of", 32'(cf_of), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'(ALUOp_SELA));
    reset = 1'b0;
    @(negedge clk);

    // Basic products and boundaries
    issue(1'b1, 16'h00FF, 16'h00FF, 32'h0000FE01, 1'b1); drain();
    issue(1'b0, 16'h1234, 16'h0010, 32'h00012340, 1'b1); drain();
    issue(1'b0, 16'h00FF, 16'h0002, 32'h000001FE, 1'b0); drain();
    issue(1'b1, 16'hAB10, 16'hCD0F, 32'h000000F0, 1'b0); drain();
    issue(1'b1, 16'h0080, 16'h0002, 32'h00000100, 1'b1); drain();
    issue(1'b1, 16'h0055, 16'h0000, 32'h00000000, 1'b0); drain();
    issue(1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF, 1'b0); drain();

    // Start during ITER is ignored; start in DONE runs back-to-back.
    issue(1'b0, 16'h0101, 16'h0003, 32'h00000303, 1'b0);
    due = exp_q[0].due;
    repeat (3) @(negedge clk);
    issue_now(1'b1, 16'hFFFF, 16'hFFFF, 32'h0, 1'b0, 1'b0);
    guard = 0;
    while (cyc < due && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    issue_now(1'b0, 16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b1);
    drain();

    // Reset in ITER cycle 5 aborts without a completion.
    @(negedge clk);
    issue_now(1'b0, 16'h1234, 16'h5678, 32'h0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_complete", 32'(complete), 32'h0);
    chk("abort_result", result, 32'h0);
    chk("abort_cf_of", 32'(cf_of), 32'h0);
    repeat (20) @(negedge clk);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
